// File: rtl/div_ctrl_if.sv
// Core-side handshake for the iterative divide sequencer: operands and op flags in,
// stall/done/result out.
interface div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic            div_signed_i;
  logic            div_rem_i;
  logic            div_w_i;
  logic [XLEN-1:0] rs1_rdata_i;
  logic [XLEN-1:0] rs2_rdata_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] res_o;

  modport master (
    output start_i, div_signed_i, div_rem_i, div_w_i, rs1_rdata_i, rs2_rdata_i, flush_i,
    input  stall_o, done_o, res_o
  );

  modport slave (
    input  start_i, div_signed_i, div_rem_i, div_w_i, rs1_rdata_i, rs2_rdata_i, flush_i,
    output stall_o, done_o, res_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms; one quotient bit per
// cycle, stalling the core while busy. Divide-by-zero and signed overflow finish at accept.
module div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic      clk_i,
  input  logic      rst_i,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] rem, quo, dvsr, res;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, rem_sel, w_sel, done;

  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_load, min_neg;
  logic            a_neg, b_neg, div_zero, ovf;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nx, quo_nx;

  function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] q, r,
                                            input logic nq, nr, sel_r, w);
    logic [XLEN-1:0] v;
    v = sel_r ? (nr ? -r : r) : (nq ? -q : q);
    if (w) v = {{(XLEN-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  always_comb begin
    if (bus.div_w_i) begin
      a_ext   = {{(XLEN-32){bus.div_signed_i & bus.rs1_rdata_i[31]}}, bus.rs1_rdata_i[31:0]};
      b_ext   = {{(XLEN-32){bus.div_signed_i & bus.rs2_rdata_i[31]}}, bus.rs2_rdata_i[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = bus.rs1_rdata_i;
      b_ext   = bus.rs2_rdata_i;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = bus.div_signed_i & a_ext[XLEN-1];
    b_neg    = bus.div_signed_i & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = bus.div_signed_i & (a_ext == min_neg) & (b_ext == '1);
    // W magnitudes sit in the top half so 32 shifts drain them and leave a clean quotient
    a_load   = bus.div_w_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
  end

  always_comb begin
    trial = {rem, quo[XLEN-1]} - {1'b0, dvsr};
    if (trial[XLEN]) begin
      rem_nx = {rem[XLEN-2:0], quo[XLEN-1]};
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      done  <= 1'b0;
      res   <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            rem     <= '0;
            quo     <= a_load;
            dvsr    <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rem_sel <= bus.div_rem_i;
            w_sel   <= bus.div_w_i;
            cnt     <= bus.div_w_i ? CW'(31) : CW'(XLEN-1);
            if (div_zero || ovf) begin
              res   <= fixup(div_zero ? '1 : a_ext, div_zero ? a_ext : '0,
                             1'b0, 1'b0, bus.div_rem_i, bus.div_w_i);
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res   <= fixup(quo_nx, rem_nx, neg_q, neg_r, rem_sel, w_sel);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o = ((state == IDLE) && bus.start_i) || (state == CALC);
  assign bus.done_o  = done;
  assign bus.res_o   = res;
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative RV64M divide sequencer for the single-cycle core. It executes DIV/DIVU/REM/REMU and their W forms with a radix-2 restoring algorithm, one quotient bit per cycle. While an operation is in flight it stalls the core. It sits beside the ALU, fed by the same rs1/rs2 operands, and its result is muxed into the rd writeback path.

## Interface
Parameters:
- XLEN, 64, datapath width; must match the core's `XLEN`.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  decoded divide/remainder instruction present. Held high by the core until done_o.
- div_signed_i  in  1  signed operation (DIV/REM/DIVW/REMW).
- div_rem_i  in  1  return remainder instead of quotient.
- div_w_i  in  1  W variant: 32-bit operation, 64-bit sign-extended result.
- rs1_rdata_i  in  XLEN  dividend.
- rs2_rdata_i  in  XLEN  divisor.
- flush_i  in  1  abort any operation in flight.
- stall_o  out  1  core must hold its PC and instruction this cycle.
- done_o  out  1  single-cycle pulse; res_o is valid.
- res_o  out  XLEN  result, registered.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Accept: in IDLE with start_i=1, the block latches operands and the three op flags at the edge. Flags and operands are ignored at all other times.
- Operand prep:
  - W: use bits [31:0]. Sign-extend when signed, zero-extend otherwise. Iteration count N=32.
  - Non-W: N=XLEN.
  - Signed: divide magnitudes. Record neg_q = sign(dividend) ^ sign(divisor) and neg_r = sign(dividend).
- Special cases are resolved at accept. The block goes IDLE -> DONE directly with no CALC.
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative value of the op width, divisor = -1): quotient = dividend; remainder = 0.
- CALC:
  - Each cycle: shift {rem, quo} left 1 and trial-subtract the divisor. If there is no borrow, keep the difference and set the quotient LSB.
  - A count register runs from N-1 down to 0. At count 0, go to DONE.
- Result fixup, applied on the edge into DONE:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select the quotient or remainder per div_rem_i.
  - For W, sign-extend bit 31 to XLEN. This applies to DIVUW/REMUW as well.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE; the core retires the instruction in that cycle.
- res_o is written only on entry to DONE and holds until the next entry to DONE.
- stall_o = (state==IDLE & start_i) | state==CALC. It is combinational and is low in DONE.
- flush_i: in CALC or DONE, go to IDLE at the next edge. done_o does not pulse and res_o is unchanged. In IDLE, flush_i suppresses accept that cycle.
- Priority: rst_i > flush_i > accept/iterate.

## Timing
- Reset values: state IDLE, done_o 0, res_o 0, stall_o = start_i (combinational).
- Normal op (start accepted at edge E0):
  - CALC occupies the N cycles after E0.
  - done_o is high in the cycle after edge E(N), i.e. N+1 cycles after the start cycle.
  - Total core stall is N+1 cycles.
- Special case: done_o is high in the cycle immediately after E0, giving 1 stall cycle.
- Back-to-back: a new start_i is accepted in the cycle after DONE at the earliest. There is no accept in the DONE cycle itself.
- rst_i mid-CALC: IDLE at the next edge, done_o 0, res_o 0.
- Flush and final iteration in the same cycle: flush wins and there is no done_o.
- Operand changes after accept have no effect.

## Test plan
- DIVU 100/7 (non-W): stall_o high for 65 cycles; done_o pulses once; res_o=14. REMU on the same operands gives 2.
- DIV -7/2 gives res_o=-3 (0xFFFF_FFFF_FFFF_FFFD). REM on the same operands gives -1 (all ones). REM 7/-2 gives 1.
- Divide by zero:
  - DIVU 5/0: done_o in the cycle after accept; res_o=0xFFFF_FFFF_FFFF_FFFF.
  - REMU 5/0: res_o=5.
  - DIV 0x8000_0000_0000_0000/-1: res_o=0x8000_0000_0000_0000.
  - REM on the same operands: res_o=0.
- W forms:
  - DIVW 0x1_0000_0007/2: res_o=3; done_o after 33 cycles.
  - DIVUW 0xFFFF_FFFF/1: res_o=0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Flush at CALC cycle 10: no done_o, res_o retains its previous value, and stall_o follows start_i the next cycle. A following DIVU 9/3 completes with res_o=3.
- rst_i asserted mid-CALC, then released: done_o=0, res_o=0. A following DIVU 9/3 completes with res_o=3.
